// File: rtl/riscv_pipeline_ctrl.sv
// Hazard and sequencing controller for a 5-stage RISC-V pipeline: load-use, branch, trap, dmem wait.
// Stall/flush/redirect outputs are combinational from state and inputs; FSM and counters are registered.
module riscv_pipeline_ctrl #(
    parameter int REG_ADDR_WIDTH    = 5,
    parameter int PC_WIDTH          = 32,
    parameter int TRAP_DRAIN_CYCLES = 2,
    parameter int PERF_CNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] decode_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] decode_rs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    input  logic                      ex_is_load,
    input  logic                      ex_branch_taken,
    input  logic [PC_WIDTH-1:0]       ex_branch_target,
    input  logic                      trap_req,
    input  logic [PC_WIDTH-1:0]       trap_target,
    input  logic                      dmem_busy,
    output logic                      fetch_stall,
    output logic                      decode_stall,
    output logic                      decode_flush,
    output logic                      ex_flush,
    output logic                      pc_load,
    output logic [PC_WIDTH-1:0]       pc_load_addr,
    output logic                      trap_taken,
    output logic [PERF_CNT_WIDTH-1:0] load_use_stalls,
    output logic [1:0]                ctrl_state
);

    typedef enum logic [1:0] {
        INIT       = 2'd0,
        RUN        = 2'd1,
        MEM_WAIT   = 2'd2,
        TRAP_DRAIN = 2'd3
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(TRAP_DRAIN_CYCLES - 1);
    localparam logic [PERF_CNT_WIDTH-1:0] PERF_ONE = {{(PERF_CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                    state;
    state_t                    state_nxt;
    logic [3:0]                drain_cnt;
    logic [3:0]                drain_nxt;
    logic                      load_use;
    logic                      count_en;
    logic [PERF_CNT_WIDTH-1:0] perf_cnt;

    // rd of x0 never carries a value, so it cannot create a hazard
    assign load_use = ex_is_load && (ex_rd_addr != '0) &&
                      ((ex_rd_addr == decode_rs1_addr) || (ex_rd_addr == decode_rs2_addr));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            drain_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cnt <= '0;
        end else if (count_en && (perf_cnt != '1)) begin
            perf_cnt <= perf_cnt + PERF_ONE;
        end
    end

    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        count_en  = 1'b0;
        case (state)
            INIT: state_nxt = RUN;
            RUN: begin
                if (trap_req) begin
                    state_nxt = TRAP_DRAIN;
                    drain_nxt = DRAIN_LOAD;
                end else if (dmem_busy) begin
                    state_nxt = MEM_WAIT;
                end else if (!ex_branch_taken && load_use) begin
                    count_en = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!dmem_busy) state_nxt = RUN;
            end
            TRAP_DRAIN: begin
                if (drain_cnt == 4'd0) state_nxt = RUN;
                else                   drain_nxt = drain_cnt - 4'd1;
            end
            default: state_nxt = INIT;
        endcase
    end

    always_comb begin
        fetch_stall  = 1'b0;
        decode_stall = 1'b0;
        decode_flush = 1'b0;
        ex_flush     = 1'b0;
        pc_load      = 1'b0;
        pc_load_addr = '0;
        trap_taken   = 1'b0;
        case (state)
            INIT: begin
                fetch_stall  = 1'b1;
                decode_flush = 1'b1;
                ex_flush     = 1'b1;
            end
            RUN: begin
                if (trap_req) begin
                    pc_load      = 1'b1;
                    pc_load_addr = trap_target;
                    trap_taken   = 1'b1;
                    decode_flush = 1'b1;
                    ex_flush     = 1'b1;
                end else if (dmem_busy) begin
                    fetch_stall  = 1'b1;
                    decode_stall = 1'b1;
                end else if (ex_branch_taken) begin
                    pc_load      = 1'b1;
                    pc_load_addr = ex_branch_target;
                    decode_flush = 1'b1;
                    ex_flush     = 1'b1;
                end else if (load_use) begin
                    fetch_stall  = 1'b1;
                    decode_stall = 1'b1;
                    ex_flush     = 1'b1;
                end
            end
            MEM_WAIT: begin
                fetch_stall  = 1'b1;
                decode_stall = 1'b1;
            end
            TRAP_DRAIN: begin
                decode_flush = 1'b1;
                ex_flush     = 1'b1;
            end
            default: begin
                fetch_stall  = 1'b1;
                decode_flush = 1'b1;
                ex_flush     = 1'b1;
            end
        endcase
        // a flush overrides a hold so the NOP actually enters decode
        if (decode_flush) decode_stall = 1'b0;
    end

    assign load_use_stalls = perf_cnt;
    assign ctrl_state      = state;

endmodule
